// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR3 user-port arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b10;

  localparam int DEF_N_CH        = 3;
  localparam int DEF_ADDR_W      = 27;
  localparam int DEF_DATA_W      = 128;
  localparam int DEF_TIMEOUT_CYC = 1023;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping modulo N.
module rr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    // Scan from farthest to nearest so the closest requester to i_ptr overwrites the rest.
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_idx = IW'((int'(i_ptr) + k) % N);
        o_any = 1'b1;
      end
    end
    o_grant = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// N-channel arbiter onto the single DDR3 user command port, one transaction in flight.
// Optional ARB_CH0_PRIORITY_EN: channel 0 always wins; round robin covers channels 1..N_CH-1.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter  int N_CH        = DEF_N_CH,
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int MASK_W      = DATA_W / 8,
  localparam int IDX_W       = idx_w(N_CH),
  localparam int WD_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CH-1:0]               req_valid,
  input  logic [N_CH-1:0]               req_write,
  input  logic [N_CH-1:0][ADDR_W-1:0]   req_addr,
  input  logic [N_CH-1:0][DATA_W-1:0]   req_wdata,
  input  logic [N_CH-1:0][MASK_W-1:0]   req_wbytes,
  output logic [N_CH-1:0]               req_ready,
  output logic [N_CH-1:0]               rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [MASK_W-1:0]             mem_wbytes,
  output logic [1:0]                    mem_en,
  output logic                          mem_new_cmd,
  input  logic                          mem_cmd_ack,
  input  logic                          mem_done,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output arb_state_e                    dbg_state
);

  // Handshake: req_valid[i] is held until req_ready[i]; req_ready is a one-cycle pulse
  // in IDLE that latches the request. rsp_valid pulses once to the owner when it completes.

  arb_state_e            r_state;
  logic [IDX_W-1:0]      r_gnt_idx;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic                  r_write;
  logic [WD_W-1:0]       r_wdog;
  logic [N_CH-1:0]       r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [MASK_W-1:0]     r_mem_wbytes;
  logic [1:0]            r_mem_en;
  logic                  r_mem_new_cmd;
  logic                  r_busy;

  logic [N_CH-1:0]       w_arb_req;
  logic [N_CH-1:0]       w_rr_grant;
  logic [IDX_W-1:0]      w_rr_idx;
  logic                  w_rr_any;
  logic [N_CH-1:0]       w_gnt_onehot;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_any;
  logic                  w_in_cmd;
  logic                  w_fin_ok;
  logic                  w_fin_to;

`ifdef ARB_CH0_PRIORITY_EN
  assign w_arb_req    = {req_valid[N_CH-1:1], 1'b0};
  assign w_any        = req_valid[0] | w_rr_any;
  assign w_gnt_idx    = req_valid[0] ? '0 : w_rr_idx;
  assign w_gnt_onehot = req_valid[0] ? N_CH'(1) : w_rr_grant;
`else
  assign w_arb_req    = req_valid;
  assign w_any        = w_rr_any;
  assign w_gnt_idx    = w_rr_idx;
  assign w_gnt_onehot = w_rr_grant;
`endif

  rr_arbiter #(.N(N_CH)) u_rr (
    .i_req   (w_arb_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  assign w_in_cmd = (r_state == ISSUE) || (r_state == WAIT);
  assign w_fin_ok = ((r_state == ISSUE) && mem_cmd_ack && mem_done) ||
                    ((r_state == WAIT) && mem_done);
  // A real completion on the last watchdog cycle wins over the abort.
  assign w_fin_to = w_in_cmd && !w_fin_ok && (r_wdog == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_gnt_idx     <= '0;
      r_rr_ptr      <= '0;
      r_write       <= 1'b0;
      r_wdog        <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wbytes  <= '0;
      r_mem_en      <= MEM_IDLE;
      r_mem_new_cmd <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_mem_new_cmd <= 1'b0;
      r_rsp_valid   <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt_idx     <= w_gnt_idx;
            r_write       <= req_write[w_gnt_idx];
            r_mem_addr    <= req_addr[w_gnt_idx];
            r_mem_wdata   <= req_wdata[w_gnt_idx];
            r_mem_wbytes  <= req_wbytes[w_gnt_idx];
            r_mem_en      <= req_write[w_gnt_idx] ? MEM_WR : MEM_RD;
            r_mem_new_cmd <= 1'b1;
            r_busy        <= 1'b1;
            r_wdog        <= '0;
            r_state       <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (w_fin_ok || w_fin_to) begin
            r_mem_en    <= MEM_IDLE;
            r_rsp_valid <= N_CH'(1) << r_gnt_idx;
            r_rsp_err   <= w_fin_to;
            r_rsp_rdata <= (w_fin_to || r_write) ? '0 : mem_rdata;
            r_state     <= RESP;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
            if ((r_state == ISSUE) && mem_cmd_ack) begin
              r_mem_en <= MEM_IDLE;
              r_state  <= WAIT;
            end
          end
        end
        RESP: begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
          r_busy      <= 1'b0;
`ifdef ARB_CH0_PRIORITY_EN
          if (r_gnt_idx != '0)
            r_rr_ptr <= (r_gnt_idx == IDX_W'(N_CH - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
`else
          r_rr_ptr <= (r_gnt_idx == IDX_W'(N_CH - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (reset && (r_state == IDLE)) ? w_gnt_onehot : '0;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wbytes  = r_mem_wbytes;
  assign mem_en      = r_mem_en;
  assign mem_new_cmd = r_mem_new_cmd;
  assign busy        = r_busy;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed scoreboard bench for ddr_port_arbiter (3 channels, 15-cycle watchdog).
module tb_ddr_port_arbiter;
  import ddr_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 27;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int TO = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid, req_write, req_ready, rsp_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [N-1:0][MW-1:0] req_wbytes;
  logic [DW-1:0]        rsp_rdata, mem_wdata, mem_rdata;
  logic                 rsp_err, mem_new_cmd, mem_cmd_ack, mem_done, busy;
  logic [AW-1:0]        mem_addr;
  logic [MW-1:0]        mem_wbytes;
  logic [1:0]           mem_en;
  arb_state_e           dbg_state;

  ddr_port_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wbytes(req_wbytes), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wbytes(mem_wbytes),
    .mem_en(mem_en), .mem_new_cmd(mem_new_cmd), .mem_cmd_ack(mem_cmd_ack),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic rst_q;
  int   cyc = 0;
  always @(posedge clk) begin
    rst_q <= reset;
    cyc   <= cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  localparam int CMD_W = 2 + AW + MW + DW;
  localparam int RSP_W = 3 + 1 + DW;
  logic [1:0]       exp_gnt_q[$];
  logic [CMD_W-1:0] exp_cmd_q[$];
  logic [RSP_W-1:0] exp_rsp_q[$];

  int total = 0;
  int bad   = 0;
  int new_cyc  = 0;
  int done_cyc = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got none want event", name);
  endtask

  task automatic push_txn(input int ch, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [MW-1:0] wb,
                          input logic [DW-1:0] rd, input logic err);
    exp_gnt_q.push_back(2'(ch));
    exp_cmd_q.push_back({(wr ? MEM_WR : MEM_RD), a, wb, wd});
    exp_rsp_q.push_back({3'(ch), err, rd});
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [RSP_W-1:0] r;
    logic [CMD_W-1:0] c;
    logic [1:0]       g;
    forever begin
      @(negedge clk);
      if (!rst_q) begin
        chk("reset_zero", {req_ready, rsp_valid, rsp_err, mem_en, mem_new_cmd, busy, dbg_state,
                           |rsp_rdata, |mem_addr, |mem_wdata, |mem_wbytes}, '0);
      end else begin
        if (mem_done) done_cyc = cyc;
        if (mem_new_cmd) begin
          new_cyc = cyc;
          if (exp_cmd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL cmd_unexp: got addr %0h want no command", mem_addr);
          end else begin
            c = exp_cmd_q.pop_front();
            chk("cmd", {mem_en, mem_addr, mem_wbytes, mem_wdata}, c);
          end
        end
        if (|req_ready) begin
          if (exp_gnt_q.size() == 0) begin
            total++; bad++;
            $display("FAIL gnt_unexp: got %0b want no grant", req_ready);
          end else begin
            g = exp_gnt_q.pop_front();
            chk("grant", req_ready, 3'b001 << g);
          end
        end
        if (|rsp_valid) begin
          if (exp_rsp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexp: got %0b want no response", rsp_valid);
          end else begin
            r = exp_rsp_q.pop_front();
            chk("rsp_ch", rsp_valid, 3'b001 << r[RSP_W-1 -: 3]);
            chk("rsp_err", rsp_err, r[DW]);
            chk("rsp_rdata", rsp_rdata, r[DW-1:0]);
            if (r[DW]) chk("rsp_lat_to", 256'(cyc - new_cyc), TO);
            else       chk("rsp_lat", 256'(cyc - done_cyc), 1);
          end
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic issue(input int ch, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wb);
    int g;
    @(posedge clk); #1;
    req_valid[ch]  = 1'b1;
    req_write[ch]  = wr;
    req_addr[ch]   = a;
    req_wdata[ch]  = wd;
    req_wbytes[ch] = wb;
    g = 0;
    do begin @(negedge clk); g++; end while (!req_ready[ch] && g < 100);
    if (!req_ready[ch]) fail_now("grant_timeout");
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic mem_serve(input int n, input int ack_dly, input int done_dly,
                           input bit no_ack, input bit no_done, input logic [DW-1:0] rd);
    int g;
    for (int t = 0; t < n; t++) begin
      g = 0;
      do begin @(posedge clk); #1; g++; end while (!mem_new_cmd && g < 100);
      if (!mem_new_cmd) begin
        fail_now("cmd_timeout");
        return;
      end
      if (!no_ack) begin
        repeat (ack_dly) begin @(posedge clk); #1; end
        mem_cmd_ack = 1'b1;
        if (!no_done && done_dly == 0) begin
          mem_done  = 1'b1;
          mem_rdata = rd;
        end
        @(posedge clk); #1;
        mem_cmd_ack = 1'b0;
        mem_done    = 1'b0;
        if (!no_done && done_dly > 0) begin
          repeat (done_dly - 1) begin @(posedge clk); #1; end
          mem_done  = 1'b1;
          mem_rdata = rd;
          @(posedge clk); #1;
          mem_done = 1'b0;
        end
      end
    end
  endtask

  task automatic rr_drive(input int n);
    int got, g;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_write[i]  = 1'b0;
      req_addr[i]   = AW'(32'h10 * (i + 1));
      req_wdata[i]  = '0;
      req_wbytes[i] = '0;
    end
    req_valid = '1;
    got = 0;
    g   = 0;
    while (got < n && g < 400) begin
      @(negedge clk);
      if (|req_ready) got++;
      g++;
    end
    if (got < n) fail_now("rr_grant_timeout");
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin @(negedge clk); g++; end while ((busy || exp_rsp_q.size() != 0) && g < 200);
    if (busy || exp_rsp_q.size() != 0) fail_now("idle_timeout");
  endtask

  // ---------------- main sequence ----------------
  localparam logic [DW-1:0] A5  = {16{8'hA5}};
  localparam logic [DW-1:0] RRD = 128'h5A5A_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [DW-1:0] WD2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    int g;
    reset       = 1'b0;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wbytes  = '0;
    mem_cmd_ack = 1'b0;
    mem_done    = 1'b0;
    mem_rdata   = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // six back-to-back transactions with all channels requesting
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_CH0_PRIORITY_EN
      g = 0;
`else
      g = k % N;
`endif
      push_txn(g, 1'b0, AW'(32'h10 * (g + 1)), '0, '0, RRD, 1'b0);
    end
    fork
      rr_drive(6);
      mem_serve(6, 0, 1, 1'b0, 1'b0, RRD);
    join
    wait_idle();

    // single read: ack one cycle after the command, done four after that
    push_txn(1, 1'b0, 27'h0000100, '0, '0, A5, 1'b0);
    fork
      issue(1, 1'b0, 27'h0000100, '0, '0);
      mem_serve(1, 1, 4, 1'b0, 1'b0, A5);
    join
    wait_idle();

    // masked write: response data must be zero regardless of mem_rdata
    push_txn(2, 1'b1, 27'h7ABCDE0, WD2, 16'h00FF, '0, 1'b0);
    fork
      issue(2, 1'b1, 27'h7ABCDE0, WD2, 16'h00FF);
      mem_serve(1, 0, 2, 1'b0, 1'b0, {4{32'hDEADBEEF}});
    join
    wait_idle();

    // ack and done together on the first issue cycle
    push_txn(0, 1'b0, 27'h0000055, '0, '0, 128'h1234, 1'b0);
    fork
      issue(0, 1'b0, 27'h0000055, '0, '0);
      mem_serve(1, 0, 0, 1'b0, 1'b0, 128'h1234);
    join
    wait_idle();

    // no ack at all -> watchdog abort, then a normal request
    push_txn(1, 1'b0, 27'h0000066, '0, '0, '0, 1'b1);
    fork
      issue(1, 1'b0, 27'h0000066, '0, '0);
      mem_serve(1, 0, 0, 1'b1, 1'b0, '0);
    join
    wait_idle();
    push_txn(2, 1'b0, 27'h0000077, '0, '0, 128'hCAFE, 1'b0);
    fork
      issue(2, 1'b0, 27'h0000077, '0, '0);
      mem_serve(1, 1, 2, 1'b0, 1'b0, 128'hCAFE);
    join
    wait_idle();

    // acked but never done -> watchdog abort out of WAIT
    push_txn(0, 1'b1, 27'h0000088, 128'h77, 16'hFFFF, '0, 1'b1);
    fork
      issue(0, 1'b1, 27'h0000088, 128'h77, 16'hFFFF);
      mem_serve(1, 2, 0, 1'b0, 1'b1, '0);
    join
    wait_idle();

    // reset while waiting for done: transaction dropped, late done ignored
    exp_gnt_q.push_back(2'd0);
    exp_cmd_q.push_back({MEM_RD, 27'h0000099, 16'h0000, 128'h0});
    fork
      issue(0, 1'b0, 27'h0000099, '0, '0);
      mem_serve(1, 0, 0, 1'b0, 1'b1, '0);
    join
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mem_done  = 1'b1;
    mem_rdata = {8{16'hBAD0}};
    @(posedge clk); #1;
    mem_done = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("busy_after_reset", busy, 1'b0);

    // recovery after reset
    push_txn(2, 1'b1, 27'h0000001, 128'hF00D, 16'hFFFF, '0, 1'b0);
    fork
      issue(2, 1'b1, 27'h0000001, 128'hF00D, 16'hFFFF);
      mem_serve(1, 0, 1, 1'b0, 1'b0, {4{32'h0BAD_F00D}});
    join
    wait_idle();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("gnt_q_left", exp_gnt_q.size(), 0);
    chk("cmd_q_left", exp_cmd_q.size(), 0);
    chk("rsp_q_left", exp_rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
